// File: rtl/cpu_execute_mc.sv
// cpu_execute_mc: registered execute stage with a valid/ready handshake,
// operand forwarding, N/Z flags, logical shifts and memory-request outputs.
// Optional feature macro: CPU_EXEC_MUL_EN builds the WIDTH-cycle shift-add
// multiplier; without it opcode 0111 completes in one cycle with o_G = 0.
module cpu_execute_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [15:0]      i_ir,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic [WIDTH-1:0] i_forward_data,
  input  logic [1:0]       i_forward_ctrl,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pc,
  output logic [15:0]      o_ir,
  output logic [WIDTH-1:0] o_G,
  output logic             o_N,
  output logic             o_Z,
  output logic [WIDTH-1:0] o_mem_data,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic             o_mem_wr,
  output logic             o_mem_rd
);
  localparam int H  = WIDTH / 2;
  localparam int SH = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_CMP  = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_MVHI = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SHR  = 4'b1110;

  logic [3:0]       op_s;
  logic [WIDTH-1:0] a_eff_s, b_eff_s, alu_res_s;
  logic             accept_s, mul_start_s, flag_op_s;

  logic             valid_q, valid_d, mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
  logic             n_q, n_d, z_q, z_d;
  logic [WIDTH-1:0] pc_q, pc_d, g_q, g_d, mem_data_q, mem_data_d, mem_addr_q, mem_addr_d;
  logic [15:0]      ir_q, ir_d;

  // Forwarding overrides the register-file operands only on the accept cycle.
  assign op_s      = i_ir[3:0];
  assign a_eff_s   = i_forward_ctrl[1] ? i_forward_data : i_A;
  assign b_eff_s   = i_forward_ctrl[0] ? i_forward_data : i_B;
  assign flag_op_s = (op_s == OP_ADD) || (op_s == OP_SUB) || (op_s == OP_CMP);
  assign accept_s  = i_valid && o_ready;

`ifdef CPU_EXEC_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  localparam logic [SH-1:0] LAST_COUNT = SH'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step_s;
  logic [SH-1:0]    count_q, count_d;

  assign o_ready     = (state_q == S_IDLE);
  assign mul_start_s = accept_s && (op_s == OP_MUL);
  assign acc_step_s  = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign o_ready     = 1'b1;
  assign mul_start_s = 1'b0;
`endif

  // Single-cycle result for every opcode; mul slot yields zero when bypassed.
  always_comb begin
    alu_res_s = a_eff_s + b_eff_s;
    case (op_s)
      OP_SUB, OP_CMP: alu_res_s = a_eff_s - b_eff_s;
      OP_MVHI:        alu_res_s = {b_eff_s[H-1:0], a_eff_s[H-1:0]};
      OP_MUL:         alu_res_s = '0;
      OP_SHL:         alu_res_s = a_eff_s << b_eff_s[SH-1:0];
      OP_SHR:         alu_res_s = a_eff_s >> b_eff_s[SH-1:0];
      default:        alu_res_s = a_eff_s + b_eff_s;
    endcase
  end

  // Next-state for outputs and the multiply sequencer; outputs hold unless written.
  always_comb begin
    valid_d    = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    pc_d       = pc_q;
    ir_d       = ir_q;
    g_d        = g_q;
    n_d        = n_q;
    z_d        = z_q;
    mem_data_d = mem_data_q;
    mem_addr_d = mem_addr_q;
`ifdef CPU_EXEC_MUL_EN
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
`endif
    if (accept_s) begin
      pc_d       = i_pc;
      ir_d       = i_ir;
      mem_data_d = a_eff_s;
      mem_addr_d = b_eff_s;
      if (mul_start_s) begin
`ifdef CPU_EXEC_MUL_EN
        state_d  = S_MUL;
        mcand_d  = a_eff_s;
        mplier_d = b_eff_s;
        acc_d    = '0;
        count_d  = '0;
`endif
      end else begin
        valid_d  = 1'b1;
        g_d      = alu_res_s;
        mem_wr_d = (op_s == OP_ST);
        mem_rd_d = (op_s == OP_LD);
        if (flag_op_s) begin
          n_d = alu_res_s[WIDTH-1];
          z_d = (alu_res_s == '0);
        end else begin
          n_d = n_q;
        end
      end
    end else begin
`ifdef CPU_EXEC_MUL_EN
      case (state_q)
        S_MUL: begin
          acc_d    = acc_step_s;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + SH'(1);
          if (count_q == LAST_COUNT) begin
            g_d     = acc_step_s;
            n_d     = acc_step_s[WIDTH-1];
            z_d     = (acc_step_s == '0);
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_MUL;
          end
        end
        default: state_d = S_IDLE;
      endcase
`endif
    end
  end

  // Output registers; reset clears everything and drops any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      pc_q       <= '0;
      ir_q       <= 16'h0000;
      g_q        <= '0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      g_q        <= g_d;
      n_q        <= n_d;
      z_q        <= z_d;
      mem_data_q <= mem_data_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef CPU_EXEC_MUL_EN
  // Multiply sequencer state; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end
`endif

  assign o_valid    = valid_q;
  assign o_mem_wr   = mem_wr_q;
  assign o_mem_rd   = mem_rd_q;
  assign o_pc       = pc_q;
  assign o_ir       = ir_q;
  assign o_G        = g_q;
  assign o_N        = n_q;
  assign o_Z        = z_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_cpu_execute_mc.sv
// Self-checking bench for cpu_execute_mc (WIDTH=16): directed cases followed
// by random instructions checked against an arithmetic reference model.
module tb_cpu_execute_mc;
  localparam int W  = 16;
  localparam int H  = W / 2;
  localparam int SH = $clog2(W);
  localparam longint unsigned MOD = 64'd1 << W;
`ifdef CPU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_pc = '0;
  logic [15:0]  i_ir = 16'h0000;
  logic [W-1:0] i_A = '0;
  logic [W-1:0] i_B = '0;
  logic [W-1:0] i_forward_data = '0;
  logic [1:0]   i_forward_ctrl = 2'b00;
  logic         o_valid;
  logic [W-1:0] o_pc;
  logic [15:0]  o_ir;
  logic [W-1:0] o_G;
  logic         o_N, o_Z;
  logic [W-1:0] o_mem_data, o_mem_addr;
  logic         o_mem_wr, o_mem_rd;

  always #5 clk = ~clk;

  cpu_execute_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_ir(i_ir), .i_A(i_A), .i_B(i_B),
    .i_forward_data(i_forward_data), .i_forward_ctrl(i_forward_ctrl),
    .o_valid(o_valid), .o_pc(o_pc), .o_ir(o_ir), .o_G(o_G), .o_N(o_N), .o_Z(o_Z),
    .o_mem_data(o_mem_data), .o_mem_addr(o_mem_addr), .o_mem_wr(o_mem_wr), .o_mem_rd(o_mem_rd)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic         exp_n = 1'b0;
  logic         exp_z = 1'b0;
  logic [W-1:0] exp_g = '0;

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference result from the opcode table, using plain integer arithmetic.
  function automatic logic [W-1:0] ref_g(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub, amt, r;
    ua  = 64'(a);
    ub  = 64'(b);
    amt = ub % (64'd1 << SH);
    case (op)
      2, 3:    r = (ua + MOD - ub) % MOD;
      6:       r = (ub % (64'd1 << H)) * (64'd1 << H) + (ua % (64'd1 << H));
      7:       r = MUL_EN ? (ua * ub) % MOD : 64'd0;
      13:      r = (ua * (64'd1 << amt)) % MOD;
      14:      r = ua / (64'd1 << amt);
      default: r = (ua + ub) % MOD;
    endcase
    return W'(r);
  endfunction

  function automatic bit sets_flags(input int op);
    return (op == 1) || (op == 2) || (op == 3) || (op == 7 && MUL_EN);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_valid"}, o_valid, 1'b0);
    chk1({tag, "_ready"}, o_ready, 1'b1);
    chkw({tag, "_G"}, o_G, '0);
    chkw({tag, "_pc"}, o_pc, '0);
    chkw({tag, "_ir"}, W'(o_ir), '0);
    chk1({tag, "_N"}, o_N, 1'b0);
    chk1({tag, "_Z"}, o_Z, 1'b0);
    chkw({tag, "_mdata"}, o_mem_data, '0);
    chkw({tag, "_maddr"}, o_mem_addr, '0);
    chk1({tag, "_wr"}, o_mem_wr, 1'b0);
    chk1({tag, "_rd"}, o_mem_rd, 1'b0);
  endtask

  // One cycle with no instruction offered: no pulses, results held.
  task automatic idle_step();
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk1("idle_valid", o_valid, 1'b0);
    chk1("idle_wr", o_mem_wr, 1'b0);
    chk1("idle_rd", o_mem_rd, 1'b0);
    chk1("idle_ready", o_ready, 1'b1);
    chkw("idle_hold_G", o_G, exp_g);
    chk1("idle_hold_N", o_N, exp_n);
    chk1("idle_hold_Z", o_Z, exp_z);
  endtask

  // Offer one instruction, wait its latency, and check every output.
  task automatic do_instr(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] fwd, input logic [1:0] ctrl);
    logic [W-1:0] ea, eb, g, pc;
    logic [15:0]  ir;
    ea = ctrl[1] ? fwd : a;
    eb = ctrl[0] ? fwd : b;
    pc = W'($urandom);
    ir = 16'($urandom);
    ir[3:0] = 4'(op);
    chk1("ready_before_accept", o_ready, 1'b1);
    i_valid = 1'b1; i_pc = pc; i_ir = ir; i_A = a; i_B = b;
    i_forward_data = fwd; i_forward_ctrl = ctrl;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_A = W'($urandom); i_B = W'($urandom);
    i_forward_data = W'($urandom); i_forward_ctrl = 2'($urandom);
`ifdef CPU_EXEC_MUL_EN
    if (op == 7) begin
      for (int c = 0; c < W; c++) begin
        chk1("mul_stall_valid", o_valid, 1'b0);
        chk1("mul_stall_ready", o_ready, 1'b0);
        @(posedge clk); #1;
      end
    end
`endif
    g = ref_g(op, ea, eb);
    exp_g = g;
    if (sets_flags(op)) begin
      exp_n = g[W-1];
      exp_z = (g == '0);
    end
    chk1("valid", o_valid, 1'b1);
    chkw("G", o_G, g);
    chk1("N", o_N, exp_n);
    chk1("Z", o_Z, exp_z);
    chkw("pc", o_pc, pc);
    chkw("ir", W'(o_ir), W'(ir));
    chkw("mem_data", o_mem_data, ea);
    chkw("mem_addr", o_mem_addr, eb);
    chk1("mem_wr", o_mem_wr, 1'(op == 5));
    chk1("mem_rd", o_mem_rd, 1'(op == 4));
    chk1("ready_after", o_ready, 1'b1);
  endtask

  initial begin
    // Power-on reset state, checked while reset is held low.
    #2;
    chk_reset_state("por");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // First accept right after release.
    do_instr(1, W'(3), W'(4), '0, 2'b00);
    chkw("add_3_4", o_G, W'(7));

    // Flags from sub/cmp, held across mv.
    do_instr(2, W'(5), W'(5), '0, 2'b00);
    chk1("sub_eq_Z", o_Z, 1'b1);
    chk1("sub_eq_N", o_N, 1'b0);
    do_instr(3, W'(1), W'(2), '0, 2'b00);
    chkw("cmp_neg_G", o_G, {W{1'b1}});
    chk1("cmp_neg_N", o_N, 1'b1);
    do_instr(0, W'(7), W'(8), '0, 2'b00);
    chk1("mv_keeps_N", o_N, 1'b1);
    chk1("mv_keeps_Z", o_Z, 1'b0);

    // Forwarding on A, then a store with forwarded B.
    do_instr(1, W'(0), W'(1), W'(16'h1234), 2'b10);
    chkw("fwd_A", o_G, W'(16'h1235));
    do_instr(5, W'(16'h00AA), W'(16'h00BB), W'(16'h0F00), 2'b01);
    chkw("st_addr_fwd", o_mem_addr, W'(16'h0F00));
    idle_step();
    do_instr(4, W'(16'h0010), W'(16'h0020), '0, 2'b00);
    idle_step();

    // mvhi and shifts.
    do_instr(6, W'(16'h00CD), W'(16'h00AB), '0, 2'b00);
    chkw("mvhi", o_G, W'(16'hABCD));
    do_instr(13, W'(16'h0001), W'(16'h0013), '0, 2'b00);
    chkw("shl", o_G, W'(16'h0008));
    do_instr(14, W'(16'h8000), W'(15), '0, 2'b00);
    chkw("shr", o_G, W'(16'h0001));

`ifdef CPU_EXEC_MUL_EN
    do_instr(7, W'(16'h0100), W'(16'h0101), '0, 2'b00);
    chkw("mul_0100_0101", o_G, W'(16'h0100));
    do_instr(7, W'(16'hFFFF), W'(16'hFFFF), '0, 2'b00);
    chkw("mul_ffff_ffff", o_G, W'(16'h0001));
    chk1("mul_ffff_N", o_N, 1'b0);
    chk1("mul_ffff_Z", o_Z, 1'b0);

    // An add held on i_valid during the stall is taken only afterwards.
    i_valid = 1'b1; i_ir = 16'h0007; i_A = W'(6); i_B = W'(7); i_forward_ctrl = 2'b00;
    @(posedge clk); #1;
    i_ir = 16'h0001; i_A = W'(16'h0100); i_B = W'(16'h0023);
    for (int c = 0; c < W; c++) begin
      chk1("held_stall_valid", o_valid, 1'b0);
      chk1("held_stall_ready", o_ready, 1'b0);
      @(posedge clk); #1;
    end
    chk1("held_mul_valid", o_valid, 1'b1);
    chkw("held_mul_G", o_G, W'(42));
    chk1("held_mul_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    exp_g = W'(16'h0123); exp_n = 1'b0; exp_z = 1'b0;
    chk1("held_add_valid", o_valid, 1'b1);
    chkw("held_add_G", o_G, exp_g);
    idle_step();

    // Reset five cycles into a multiply discards it.
    i_valid = 1'b1; i_ir = 16'h0007; i_A = W'(3); i_B = W'(5);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk_reset_state("mid_mul_rst");
`else
    // Without the multiplier, opcode 0111 is a one-cycle zero with flags held.
    do_instr(3, W'(1), W'(2), '0, 2'b00);
    do_instr(7, W'(5), W'(6), '0, 2'b00);
    chkw("mul_off_G", o_G, '0);
    chk1("mul_off_N_held", o_N, 1'b1);

    // Reset right after an instruction completes.
    do_instr(1, W'(9), W'(9), '0, 2'b00);
    reset = 1'b0;
    #1;
    chk_reset_state("mid_op_rst");
`endif
    exp_g = '0; exp_n = 1'b0; exp_z = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < W + 2; c++) idle_step();
    do_instr(1, W'(3), W'(4), '0, 2'b00);
    chkw("post_rst_add", o_G, W'(7));

    // Random instruction stream, back-to-back with occasional idle cycles.
    for (int i = 0; i < 60; i++) begin
      do_instr(int'($urandom_range(0, 15)), W'($urandom), W'($urandom),
               W'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) idle_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_execute_mc.md
# cpu_execute_mc

Parametrised, registered execute stage for the pipelined CPU. It sits between decode/register-read and memory/writeback, and extends the single-cycle ALU with the following:
- configurable datapath width;
- a valid/ready handshake to the upstream stage;
- logical shifts;
- an iterative multi-cycle multiply that stalls the pipeline while it runs.

Operand forwarding, N/Z flag generation and memory-request generation are preserved.

## Interface
Parameters:
- WIDTH, 16: datapath width. Must be even and ≥ 8. H = WIDTH/2. SH = $clog2(WIDTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept an instruction this cycle
- i_pc, i_ir  in  WIDTH, 16  PC and instruction; opcode = i_ir[3:0]
- i_A, i_B  in  WIDTH  register-file operands
- i_forward_data  in  WIDTH  bypass value
- i_forward_ctrl  in  2  bit1: replace A; bit0: replace B
- o_valid  out  1  one-cycle pulse per completed instruction
- o_pc, o_ir  out  WIDTH, 16  registered copies of the accepted pc/ir
- o_G  out  WIDTH  result
- o_N, o_Z  out  1  flags
- o_mem_data, o_mem_addr  out  WIDTH  registered A, B
- o_mem_wr, o_mem_rd  out  1  store/load request, qualified by o_valid

## Operation
- Accept happens when `i_valid && o_ready` at a rising edge. At accept, effective operands are latched:
  - A = ctrl[1] ? fwd : i_A
  - B = ctrl[0] ? fwd : i_B
- Forwarding is sampled only on the accept cycle.
- Opcodes and results (all arithmetic is mod 2^WIDTH):

| Opcode | Instruction | Result |
|---|---|---|
| 0000 | mv | A+B |
| 0001 | add | A+B |
| 0010 | sub | A−B |
| 0011 | cmp | A−B |
| 0100 | ld | A+B |
| 0101 | st | A+B |
| 0110 | mvhi | {B[H-1:0], A[H-1:0]} |
| 0111 | mul | low WIDTH bits of A×B, unsigned |
| 1000 | jr | A+B |
| 1001 | jzr | A+B |
| 1010 | jnr | A+B |
| 1100 | callr | A+B |
| 1101 | shl | A << B[SH-1:0] |
| 1110 | shr | A >> B[SH-1:0], logical |
| other | — | A+B |

- Flags:
  - N = result[WIDTH-1] and Z = (result == 0).
  - Written only for add, sub, cmp and mul, at the same edge as o_G; otherwise held.
- Memory requests:
  - o_mem_wr = o_valid for st; o_mem_rd = o_valid for ld.
  - o_mem_data = A and o_mem_addr = B, as latched at accept.
- FSM:
  - IDLE (o_ready=1):
    - Non-mul accept: outputs register at the same edge, o_valid=1 next cycle.
    - mul accept: latch multiplicand, multiplier and pc/ir; clear accumulator and count; go to MUL.
    - No accept: o_valid=0 next cycle. o_mem_wr and o_mem_rd are 0; all other outputs hold.
  - MUL (o_ready=0):
    - Each edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count++.
    - On the edge where count reaches WIDTH-1: write o_G = acc result and flags, pulse o_valid, return to IDLE.
- While o_ready=0, i_valid is ignored. Upstream holds its instruction.
- Reset (asserted at any time, including mid-MUL):
  - State goes to IDLE and the in-progress multiply is discarded with no o_valid.
  - All outputs are 0, except o_ready=1.

## Timing
- Non-mul: accepted at edge k, outputs and o_valid visible after edge k (1-cycle latency). Back-to-back accepts sustain 1 instr/cycle.
- mul:
  - Accepted at edge k. Result, flags and o_valid are visible after edge k+WIDTH.
  - o_ready is low from after edge k until after edge k+WIDTH, i.e. WIDTH cycles.
  - The next accept is possible at edge k+WIDTH+1.
- o_valid, o_mem_wr and o_mem_rd are single-cycle pulses; never high two cycles for one instruction.
- Reset release: first accept is possible at the first rising edge after deassertion.

## Configuration
- CPU_EXEC_MUL_EN defined: mul is implemented as above (WIDTH-cycle iterative).
- Not defined:
  - No MUL state or multiply datapath is built.
  - Opcode 0111 completes in 1 cycle with o_G=0 and flags unchanged.
  - o_ready is constantly 1 outside reset.

## Test plan
- Reset: assert reset mid-operation, then release. Required: all outputs 0, o_ready=1; first add 0x0003+0x0004 gives o_G=0x0007, N=0, Z=0, o_valid after 1 edge.
- sub and cmp flags: 0x0005−0x0005 gives Z=1, N=0; 0x0001−0x0002 gives o_G=0xFFFF, N=1. A following mv leaves the flags unchanged.
- Forwarding: ctrl=2'b10, fwd=0x1234, i_A=0, i_B=1 gives o_G=0x1235. A st with ctrl=2'b01 gives o_mem_addr=fwd and a single-cycle o_mem_wr pulse.
- mvhi and shifts (WIDTH=16):
  - mvhi A=0x00CD, B=0x00AB gives 0xABCD.
  - shl 0x0001 by B=0x0013 (amount 3) gives 0x0008.
  - shr 0x8000 by 15 gives 0x0001.
- Multiply (MUL_EN, WIDTH=16):
  - 0x0100 × 0x0101 gives 0x0100 with o_valid exactly 16 edges after accept. o_ready is low for 16 cycles; an i_valid held during the stall is accepted only afterwards.
  - 0xFFFF × 0xFFFF gives 0x0001, Z=0, N=0.
- Reset mid-multiply: assert reset 5 cycles into a mul. Required: no o_valid, o_G=0, o_ready=1; the next add completes normally. Repeat the suite with WIDTH=32.
